// File: rtl/rv64i_io_pkg.sv
// Shared types and width helpers for the rv64i store-capture I/O block.
package rv64i_io_pkg;

  // Channel index width: at least one bit, even for a single channel.
  function automatic int unsigned ch_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy width: must be able to represent DEPTH itself.
  function automatic int unsigned cnt_width(int unsigned d);
    return $clog2(d) + 1;
  endfunction

  // Widths of the default build (4 channels, 16 entries, 64-bit data).
  localparam int unsigned CH_W  = ch_width(4);
  localparam int unsigned CNT_W = cnt_width(16);

  typedef struct packed {
    logic [CH_W-1:0] channel;
    logic [63:0]     data;
  } io_entry_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_PENDING
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push is accepted while full if a pop happens in the
// same cycle. The read port holds the last popped value while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? last_q : mem[rd_ptr];

  // Storage array write; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the held read value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_store_capture.sv
// Snoops core stores to a bank of I/O addresses and queues {channel, data}
// entries for a valid/ready consumer, with stall or drop-and-flag on full.
module io_store_capture
  import rv64i_io_pkg::*;
#(
  parameter int unsigned     XLEN          = 64,
  parameter int unsigned     NUM_CHANNELS  = 4,
  parameter logic [XLEN-1:0] BASE_ADDR     = '0,
  parameter int unsigned     ADDR_STRIDE   = 8,
  parameter int unsigned     DEPTH         = 16,
  parameter bit              STALL_ON_FULL = 1'b1,
  localparam int unsigned    CH_BITS       = ch_width(NUM_CHANNELS),
  localparam int unsigned    CNT_BITS      = cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     io_out_addr,
  input  logic [XLEN-1:0]     mem_out,
  input  logic                memory_we,
  output logic                mem_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_BITS-1:0]  out_channel,
  output logic [XLEN-1:0]     out_data,
  output logic [CNT_BITS-1:0] fill_count,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int unsigned STRIDE_SH = $clog2(ADDR_STRIDE);

  typedef struct packed {
    logic [CH_BITS-1:0] channel;
    logic [XLEN-1:0]    data;
  } entry_t;

  cap_state_t      state_q, state_d;
  entry_t          pend_q, pend_d;
  entry_t          store_entry, push_entry, head;
  logic            we_q;
  logic            store_evt, store_hit;
  logic [XLEN-1:0] offset, slot_idx;
  logic            low_ok;
  logic            push, set_ovf, slot, fifo_full, fifo_empty;

  // Rising edge of the store strobe is the store event.
  assign store_evt = memory_we & ~we_q;

  // Address decode: aligned to the stride and within the channel range.
  assign offset      = io_out_addr - BASE_ADDR;
  assign low_ok      = (offset & XLEN'(ADDR_STRIDE - 1)) == '0;
  assign slot_idx    = offset >> STRIDE_SH;
  assign store_hit   = store_evt & low_ok & (slot_idx < XLEN'(NUM_CHANNELS));
  assign store_entry = '{channel: slot_idx[CH_BITS-1:0], data: mem_out};

  // A slot exists if not full, or if the head leaves this cycle.
  assign slot = ~fifo_full | (out_ready & ~fifo_empty);

  // Next-state, push selection and overflow detection.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    push       = 1'b0;
    push_entry = store_entry;
    set_ovf    = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (store_hit) begin
          if (slot) begin
            push = 1'b1;
          end else if (STALL_ON_FULL) begin
            state_d = CAP_PENDING;
            pend_d  = store_entry;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      CAP_PENDING: begin
        if (slot) begin
          push       = 1'b1;
          push_entry = pend_q;
          state_d    = CAP_IDLE;
        end
        if (store_hit) set_ovf = 1'b1;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // State, pending entry, strobe history and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CAP_IDLE;
      pend_q   <= '0;
      we_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      we_q    <= memory_we;
      if (set_ovf)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // mem_ready is a registered view of the FSM: low only while PENDING.
  assign mem_ready = (state_q == CAP_IDLE);

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_count)
  );

  assign out_valid   = ~fifo_empty;
  assign out_channel = head.channel;
  assign out_data    = head.data;

endmodule

// File: tb/tb_io_store_capture.sv
// Directed bench: instance 0 stalls on full, instance 1 drops and flags.
module tb_io_store_capture;
  import rv64i_io_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic [63:0] io_out_addr  [2];
  logic [63:0] mem_out      [2];
  logic        memory_we    [2];
  logic        out_ready    [2];
  logic        overflow_clr [2];
  logic        mem_ready    [2];
  logic        out_valid    [2];
  logic [1:0]  out_channel  [2];
  logic [63:0] out_data     [2];
  logic [4:0]  fill_count   [2];
  logic        overflow     [2];

  int errors = 0;
  int checks = 0;

  io_store_capture #(
    .XLEN(64), .NUM_CHANNELS(4), .BASE_ADDR(64'h0), .ADDR_STRIDE(8),
    .DEPTH(16), .STALL_ON_FULL(1'b1)
  ) u_stall (
    .clk(clk), .rst(rst[0]), .io_out_addr(io_out_addr[0]), .mem_out(mem_out[0]),
    .memory_we(memory_we[0]), .mem_ready(mem_ready[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_channel(out_channel[0]), .out_data(out_data[0]),
    .fill_count(fill_count[0]), .overflow(overflow[0]), .overflow_clr(overflow_clr[0])
  );

  io_store_capture #(
    .XLEN(64), .NUM_CHANNELS(4), .BASE_ADDR(64'h0), .ADDR_STRIDE(8),
    .DEPTH(16), .STALL_ON_FULL(1'b0)
  ) u_drop (
    .clk(clk), .rst(rst[1]), .io_out_addr(io_out_addr[1]), .mem_out(mem_out[1]),
    .memory_we(memory_we[1]), .mem_ready(mem_ready[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_channel(out_channel[1]), .out_data(out_data[1]),
    .fill_count(fill_count[1]), .overflow(overflow[1]), .overflow_clr(overflow_clr[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int d, input logic [63:0] a, input logic [63:0] v);
    io_out_addr[d] = a;
    mem_out[d]     = v;
    memory_we[d]   = 1'b1;
    tick();
    memory_we[d]   = 1'b0;
    tick();
  endtask

  task automatic pop1(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic check_head(input int d, input string tag, input logic [1:0] ch, input logic [63:0] v);
    check({tag, "_valid"}, 64'(out_valid[d]), 64'd1);
    check({tag, "_ch"}, 64'(out_channel[d]), 64'(ch));
    check({tag, "_data"}, out_data[d], v);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; io_out_addr[d] = '0; mem_out[d] = '0;
      memory_we[d] = 1'b0; out_ready[d] = 1'b0; overflow_clr[d] = 1'b0;
    end
    tick(); tick();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();

    // Reset state of both instances
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 64'(out_valid[d]), 64'd0);
      check("rst_fill", 64'(fill_count[d]), 64'd0);
      check("rst_ovf", 64'(overflow[d]), 64'd0);
      check("rst_ready", 64'(mem_ready[d]), 64'd1);
      check("rst_data", out_data[d], 64'd0);
      check("rst_ch", 64'(out_channel[d]), 64'd0);
    end

    // Single store to channel 0, visible one cycle later
    io_out_addr[0] = 64'h0;
    mem_out[0]     = 64'h0F0F07F0_0F0F07F0;
    memory_we[0]   = 1'b1;
    tick();
    check_head(0, "t1", 2'd0, 64'h0F0F07F0_0F0F07F0);
    check("t1_fill", 64'(fill_count[0]), 64'd1);
    memory_we[0] = 1'b0;
    tick();
    pop1(0);
    check("t1_fill_after_pop", 64'(fill_count[0]), 64'd0);
    check("t1_valid_after_pop", 64'(out_valid[0]), 64'd0);
    check("t1_hold_data", out_data[0], 64'h0F0F07F0_0F0F07F0);

    // Decode: unaligned and out-of-range addresses are ignored
    store(0, 64'h8,  64'hA1);
    store(0, 64'h4,  64'hE4);
    store(0, 64'h18, 64'hB3);
    store(0, 64'h20, 64'hC4);
    check("t2_fill", 64'(fill_count[0]), 64'd2);
    check_head(0, "t2_first", 2'd1, 64'hA1);
    pop1(0);
    check_head(0, "t2_second", 2'd3, 64'hB3);
    pop1(0);
    check("t2_fill_end", 64'(fill_count[0]), 64'd0);

    // Strobe held high for five cycles yields one entry
    io_out_addr[0] = 64'h10;
    mem_out[0]     = 64'h55;
    memory_we[0]   = 1'b1;
    repeat (5) tick();
    memory_we[0]   = 1'b0;
    tick();
    check("t3_fill", 64'(fill_count[0]), 64'd1);
    check_head(0, "t3", 2'd2, 64'h55);
    pop1(0);

    // Stall mode: fill, then one more store stalls the core
    for (int i = 0; i < 16; i++) store(0, 64'((i % 4) * 8), 64'(i));
    check("t4_fill16", 64'(fill_count[0]), 64'd16);
    check("t4_ready_full", 64'(mem_ready[0]), 64'd1);
    io_out_addr[0] = 64'h0;
    mem_out[0]     = 64'hDEAD;
    memory_we[0]   = 1'b1;
    tick();
    check("t4_ready_low", 64'(mem_ready[0]), 64'd0);
    memory_we[0]   = 1'b0;
    tick();
    check("t4_ready_still_low", 64'(mem_ready[0]), 64'd0);
    check("t4_fill_pending", 64'(fill_count[0]), 64'd16);
    check_head(0, "t4_head0", 2'd0, 64'd0);
    pop1(0);
    check("t4_ready_back", 64'(mem_ready[0]), 64'd1);
    check("t4_fill_after", 64'(fill_count[0]), 64'd16);
    check("t4_ovf", 64'(overflow[0]), 64'd0);
    check_head(0, "t4_head1", 2'd1, 64'd1);

    // Enter PENDING again, then a second store is a protocol violation
    store(0, 64'h8, 64'hBEEF);
    check("t4b_ready_low", 64'(mem_ready[0]), 64'd0);
    io_out_addr[0] = 64'h10;
    mem_out[0]     = 64'h99;
    memory_we[0]   = 1'b1;
    tick();
    check("t4b_ovf", 64'(overflow[0]), 64'd1);
    check("t4b_ready", 64'(mem_ready[0]), 64'd0);
    check("t4b_fill", 64'(fill_count[0]), 64'd16);
    memory_we[0] = 1'b0;
    tick();

    // Asynchronous reset while PENDING takes effect without a clock edge
    rst[0] = 1'b0;
    #1;
    check("t6_rst_ready", 64'(mem_ready[0]), 64'd1);
    check("t6_rst_fill", 64'(fill_count[0]), 64'd0);
    check("t6_rst_valid", 64'(out_valid[0]), 64'd0);
    check("t6_rst_ovf", 64'(overflow[0]), 64'd0);
    tick();
    rst[0] = 1'b1;
    tick();

    // Drop mode: store to a full FIFO is lost and flagged
    for (int i = 0; i < 16; i++) store(1, 64'((i % 4) * 8), 64'(i));
    check("t5_fill16", 64'(fill_count[1]), 64'd16);
    io_out_addr[1] = 64'h0;
    mem_out[1]     = 64'hAA;
    memory_we[1]   = 1'b1;
    tick();
    check("t5_ovf_set", 64'(overflow[1]), 64'd1);
    check("t5_fill", 64'(fill_count[1]), 64'd16);
    check("t5_ready", 64'(mem_ready[1]), 64'd1);
    memory_we[1] = 1'b0;
    tick();
    check("t5_ovf_sticky", 64'(overflow[1]), 64'd1);
    overflow_clr[1] = 1'b1;
    tick();
    check("t5_ovf_clr", 64'(overflow[1]), 64'd0);
    memory_we[1] = 1'b1;
    tick();
    check("t5_set_wins", 64'(overflow[1]), 64'd1);
    memory_we[1] = 1'b0;
    tick();
    check("t5_clr_again", 64'(overflow[1]), 64'd0);
    overflow_clr[1] = 1'b0;

    // Push and pop together at full: count unchanged, nothing lost
    out_ready[1]   = 1'b1;
    io_out_addr[1] = 64'h18;
    mem_out[1]     = 64'h77;
    memory_we[1]   = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    memory_we[1] = 1'b0;
    check("t7_fill", 64'(fill_count[1]), 64'd16);
    check("t7_ovf", 64'(overflow[1]), 64'd0);
    tick();
    for (int i = 1; i < 16; i++) begin
      check_head(1, $sformatf("t7_drain%0d", i), 2'(i % 4), 64'(i));
      pop1(1);
    end
    check_head(1, "t7_last", 2'd3, 64'h77);
    pop1(1);
    check("t7_empty", 64'(out_valid[1]), 64'd0);
    check("t7_fill_end", 64'(fill_count[1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
